// File: rtl/matmul_seq.sv
// Matrix-multiply sequencer: polls the MMIO flag, runs C = A*B on
// a single signed MAC over memory port B, then clears the flag.
module matmul_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         mem_we,
  input  logic signed [DATA_WIDTH-1:0] mem_rdata,
  output logic                         busy,
  output logic                         done
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int DW2 = 2 * DATA_WIDTH;

  localparam logic [AW-1:0] A_REG = AW'('h000);
  localparam logic [AW-1:0] B_REG = AW'('h100);
  localparam logic [AW-1:0] C_REG = AW'('h200);
  localparam logic [AW-1:0] M_REG = AW'('h600);
  localparam logic [AW-1:0] N_REG = AW'('h700);
  localparam logic [AW-1:0] P_REG = AW'('h800);
  localparam logic [AW-1:0] F_REG = AW'('hA00);

  typedef enum logic [2:0] {
    S_POLL_REQ, S_POLL_CHK, S_CFG, S_RD_A,
    S_RD_B, S_MAC, S_WR_C, S_FIN
  } state_t;

  state_t state, state_nx;

  logic [2:0] cfg_cnt;
  logic [AW-1:0] a_base, b_base, c_base;
  logic [AW-1:0] a_row, a_ptr, b_col, b_ptr, c_ptr;
  logic [DW-1:0] m, n, p, i, j, k;
  logic signed [DW-1:0] a_reg;
  logic signed [DW2-1:0] acc, prod;
  logic last_i, last_j, last_k;

  assign prod = DW2'(a_reg) * DW2'(mem_rdata);
  assign last_i = (i == m - DW'(1));
  assign last_j = (j == p - DW'(1));
  assign last_k = (k == n - DW'(1));

  // Address pointers walk A along a row, B down a column, C linearly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_POLL_REQ;
      cfg_cnt <= '0;
      a_base  <= '0;
      b_base  <= '0;
      c_base  <= '0;
      a_row   <= '0;
      a_ptr   <= '0;
      b_col   <= '0;
      b_ptr   <= '0;
      c_ptr   <= '0;
      m       <= '0;
      n       <= '0;
      p       <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      a_reg   <= '0;
      acc     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_CFG: begin
          cfg_cnt <= cfg_cnt + 3'd1;
          unique case (cfg_cnt)
            3'd1: a_base <= mem_rdata[AW-1:0];
            3'd2: b_base <= mem_rdata[AW-1:0];
            3'd3: c_base <= mem_rdata[AW-1:0];
            3'd4: m <= mem_rdata;
            3'd5: n <= mem_rdata;
            3'd6: begin
              p       <= mem_rdata;
              cfg_cnt <= '0;
              i       <= '0;
              j       <= '0;
              k       <= '0;
              acc     <= '0;
              a_row   <= a_base;
              a_ptr   <= a_base;
              b_col   <= b_base;
              b_ptr   <= b_base;
              c_ptr   <= c_base;
            end
            default: ;
          endcase
        end
        S_RD_B: a_reg <= mem_rdata;
        S_MAC: begin
          acc <= acc + prod;
          if (!last_k) begin
            k     <= k + DW'(1);
            a_ptr <= a_ptr + AW'(1);
            b_ptr <= b_ptr + p[AW-1:0];
          end
        end
        S_WR_C: begin
          k     <= '0;
          acc   <= '0;
          c_ptr <= c_ptr + AW'(1);
          if (last_j) begin
            j     <= '0;
            i     <= i + DW'(1);
            a_row <= a_row + n[AW-1:0];
            a_ptr <= a_row + n[AW-1:0];
            b_col <= b_base;
            b_ptr <= b_base;
          end else begin
            j     <= j + DW'(1);
            a_ptr <= a_row;
            b_col <= b_col + AW'(1);
            b_ptr <= b_col + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_POLL_REQ: begin
        if (en) begin
          mem_addr = F_REG;
          state_nx = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        state_nx = (mem_rdata != '0) ? S_CFG : S_POLL_REQ;
      end
      S_CFG: begin
        busy = 1'b1;
        unique case (cfg_cnt)
          3'd0: mem_addr = A_REG;
          3'd1: mem_addr = B_REG;
          3'd2: mem_addr = C_REG;
          3'd3: mem_addr = M_REG;
          3'd4: mem_addr = N_REG;
          3'd5: mem_addr = P_REG;
          default: mem_addr = '0;
        endcase
        if (cfg_cnt == 3'd6) begin
          if (m == '0 || n == '0 || mem_rdata == '0)
            state_nx = S_FIN;
          else
            state_nx = S_RD_A;
        end
      end
      S_RD_A: begin
        busy     = 1'b1;
        mem_addr = a_ptr;
        state_nx = S_RD_B;
      end
      S_RD_B: begin
        busy     = 1'b1;
        mem_addr = b_ptr;
        state_nx = S_MAC;
      end
      S_MAC: begin
        busy     = 1'b1;
        state_nx = last_k ? S_WR_C : S_RD_A;
      end
      S_WR_C: begin
        busy      = 1'b1;
        mem_addr  = c_ptr;
        mem_wdata = acc[DW-1:0];
        mem_we    = 1'b1;
        state_nx  = (last_i && last_j) ? S_FIN : S_RD_A;
      end
      S_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        mem_addr = F_REG;
        mem_we   = 1'b1;
        state_nx = S_POLL_REQ;
      end
      default: state_nx = S_POLL_REQ;
    endcase
    // Reset silences the bus in the same cycle so an aborted job never writes.
    if (!rst_n) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq with a 1-cycle-latency
// SRAM/MMIO model on port B.
module tb_matmul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic signed [31:0] mem_rdata;
  logic        busy;
  logic        done;

  matmul_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int wr_cnt = 0, we_cnt = 0, busy_cnt = 0;
  int busy_len = 0, done_len = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    int bl;
    bl = busy ? (busy_q ? busy_len + 1 : 1) : 0;
    busy_len = bl;
    busy_q = busy;
    if (done) done_len = bl;
    if (mem_we) we_cnt++;
    if (busy) busy_cnt++;
    if (mem_we && mem_addr != 16'hA00) wr_cnt++;
  end

  typedef struct packed {
    int m;
    int n;
    int p;
    logic [31:0] flag;
    logic [0:5][31:0] a;
    logic [0:5][31:0] b;
    logic [0:5][31:0] c;
    int lat;
  } vec_t;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  vec_t vec [0:4];
  int pass_cnt = 0, total_cnt = 0;
  int wr_base;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] abase(input int s);
    return 16'(32'h1000 + s * 64);
  endfunction
  function automatic logic [15:0] bbase(input int s);
    return 16'(32'h2000 + s * 64);
  endfunction
  function automatic logic [15:0] cbase(input int s);
    return 16'(32'h3000 + s * 64);
  endfunction

  task automatic start_job(input vec_t t, input int s);
    for (int e = 0; e < t.m * t.n; e++) mem[16'(abase(s) + e)] = t.a[e];
    for (int e = 0; e < t.n * t.p; e++) mem[16'(bbase(s) + e)] = t.b[e];
    for (int e = 0; e < 7; e++) mem[16'(cbase(s) + e)] = SENT;
    mem[16'h000] = 32'(abase(s));
    mem[16'h100] = 32'(bbase(s));
    mem[16'h200] = 32'(cbase(s));
    mem[16'h600] = t.m;
    mem[16'h700] = t.n;
    mem[16'h800] = t.p;
    mem[16'hA00] = t.flag;
    wr_base = wr_cnt;
  endtask

  task automatic finish_job(input vec_t t, input int s, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(done_len), 64'(t.lat));
    tick();
    check({tag, " flag clear"}, 64'(mem[16'hA00]), 64'd0);
    check({tag, " write count"}, 64'(wr_cnt - wr_base), 64'(t.m * t.p));
    for (int e = 0; e < t.m * t.p; e++)
      check($sformatf("%s c[%0d]", tag, e),
            64'(mem[16'(cbase(s) + e)]), 64'(t.c[e]));
    check({tag, " c past end"},
          64'(mem[16'(cbase(s) + t.m * t.p)]), 64'(SENT));
  endtask

  initial begin
    int we0, busy0;
    bit seen;

    vec[0].m = 2; vec[0].n = 2; vec[0].p = 2; vec[0].flag = 32'd1;
    vec[0].a = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0};
    vec[0].b = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd0, 32'd0};
    vec[0].c = '{32'd19, 32'd22, 32'd43, 32'd50, 32'd0, 32'd0};
    vec[0].lat = 36;

    vec[1].m = 1; vec[1].n = 1; vec[1].p = 1; vec[1].flag = 32'h8000_0000;
    vec[1].a = '{32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[1].b = '{32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[1].c = '{32'hFFFF_FFF4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[1].lat = 12;

    vec[2].m = 1; vec[2].n = 2; vec[2].p = 1; vec[2].flag = 32'd7;
    vec[2].a = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[2].b = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[2].c = '{32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[2].lat = 15;

    vec[3].m = 3; vec[3].n = 1; vec[3].p = 2; vec[3].flag = 32'd1;
    vec[3].a = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0};
    vec[3].b = '{32'd4, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[3].c = '{32'd4, 32'hFFFF_FFFB, 32'd8, 32'hFFFF_FFF6,
                 32'd12, 32'hFFFF_FFF1};
    vec[3].lat = 32;

    vec[4].m = 0; vec[4].n = 2; vec[4].p = 2; vec[4].flag = 32'd1;
    vec[4].a = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd0, 32'd0};
    vec[4].b = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd0, 32'd0};
    vec[4].c = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vec[4].lat = 8;

    for (int a = 0; a < 65536; a++) mem[a] = '0;

    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    check("reset outputs", {mem_addr, mem_wdata, mem_we, busy, done},
          64'd0);
    rst_n = 1'b1;

    // Each job is armed in the POLL_REQ cycle right after the previous done.
    for (int v = 0; v < 5; v++) begin
      start_job(vec[v], v);
      finish_job(vec[v], v, $sformatf("vec%0d", v));
    end

    en = 1'b0;
    start_job(vec[0], 5);
    we0 = we_cnt;
    busy0 = busy_cnt;
    repeat (20) tick();
    check("gate no writes", 64'(we_cnt - we0), 64'd0);
    check("gate no busy", 64'(busy_cnt - busy0), 64'd0);
    en = 1'b1;
    tick();
    tick();
    check("gate start", 64'(busy), 64'd1);
    finish_job(vec[0], 5, "gate");

    start_job(vec[0], 6);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (busy) seen = 1'b1;
    end
    check("rst busy rise", 64'(seen), 64'd1);
    repeat (16) tick();
    rst_n = 1'b0;
    we0 = we_cnt;
    tick();
    check("rst outputs", {mem_addr, mem_wdata, mem_we, busy, done},
          64'd0);
    tick();
    check("rst no writes", 64'(we_cnt - we0), 64'd0);
    check("rst partial c0", 64'(mem[cbase(6)]), 64'd19);
    check("rst partial c1", 64'(mem[16'(cbase(6) + 1)]), 64'(SENT));
    check("rst flag kept", 64'(mem[16'hA00]), 64'd1);
    wr_base = wr_cnt;
    rst_n = 1'b1;
    finish_job(vec[0], 6, "rerun");

    for (int e = 0; e < 4; e++)
      check($sformatf("slot0 kept c[%0d]", e),
            64'(mem[16'(cbase(0) + e)]), 64'(vec[0].c[e]));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
